// File: rtl/tmds_channel_decoder_pkg.sv
// Shared definitions for the TMDS channel decoder.
// Holds the four control-token codes (TMDS_CTRL_00/01/10/11), which must match
// the transmit-side encoder, the word-aligner state encoding and the
// data-symbol decode helper.
package tmds_channel_decoder_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  // Undo the encoder's optional inversion (bit 9), then undo its XOR/XNOR
  // chaining (bit 8 selects XOR) to recover the pixel byte.
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = 8'h00;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// TMDS symbol aligner: two-word input history, 10-bit window barrel shifter,
// control-token detect and the SEARCH/LOCKED alignment FSM.
// Ports:
//   pclk_i        pixel clock
//   reset_ni      asynchronous active-low reset
//   raw_din_i     unaligned deserialized word, bit 0 earliest
//   w_o           aligned 10-bit window (combinational)
//   is_token_o    window holds one of the four control tokens
//   tok_code_o    {c1,c0} of the detected token
//   locked_o      alignment locked (registered)
//   bit_offset_o  current window offset 0..9 (registered)
module tmds_word_aligner #(
  parameter int TOKEN_CNT      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pclk_i,
  input  logic       reset_ni,
  input  logic [9:0] raw_din_i,
  output logic [9:0] w_o,
  output logic       is_token_o,
  output logic [1:0] tok_code_o,
  output logic       locked_o,
  output logic [3:0] bit_offset_o
);
  import tmds_channel_decoder_pkg::*;

  localparam int TW = (TOKEN_CNT > 1) ? $clog2(TOKEN_CNT) : 1;
  localparam int SW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int LW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [TW-1:0] TOK_LAST  = TW'(TOKEN_CNT - 1);
  localparam logic [SW-1:0] TMR_LAST  = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);

  logic [9:0]    raw_q;
  logic [9:0]    raw_qq;
  logic [19:0]   stream_s;
  logic [9:0]    w_s;
  logic          is_token_s;
  logic [1:0]    tok_code_s;
  align_state_e  state_q;
  logic [TW-1:0] tok_run_q;
  logic [SW-1:0] tmr_q;
  logic [LW-1:0] loss_tmr_q;
  logic [3:0]    off_q;
  logic          locked_q;

  // Input history: the older word sits in the low half so stream bits run in serial order.
  always_ff @(posedge pclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      raw_q  <= 10'h000;
      raw_qq <= 10'h000;
    end else begin
      raw_q  <= raw_din_i;
      raw_qq <= raw_q;
    end
  end

  assign stream_s = {raw_q, raw_qq};
  assign w_s      = stream_s[{1'b0, off_q} +: 10];

  // Control token detect on the aligned window.
  always_comb begin
    is_token_s = 1'b1;
    tok_code_s = 2'b00;
    case (w_s)
      TMDS_CTRL_00: tok_code_s = 2'b00;
      TMDS_CTRL_01: tok_code_s = 2'b01;
      TMDS_CTRL_10: tok_code_s = 2'b10;
      TMDS_CTRL_11: tok_code_s = 2'b11;
      default:      is_token_s = 1'b0;
    endcase
  end

  // Alignment FSM: count token runs per offset, step offset on timeout, drop lock when tokens vanish.
  always_ff @(posedge pclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_SEARCH;
      tok_run_q  <= '0;
      tmr_q      <= '0;
      loss_tmr_q <= '0;
      off_q      <= 4'd0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          // Lock takes priority over a coincident timeout so the offset is not stepped away.
          if (is_token_s && (tok_run_q == TOK_LAST)) begin
            state_q    <= ST_LOCKED;
            locked_q   <= 1'b1;
            tok_run_q  <= '0;
            tmr_q      <= '0;
            loss_tmr_q <= '0;
          end else if (tmr_q == TMR_LAST) begin
            off_q     <= (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
            tmr_q     <= '0;
            tok_run_q <= '0;
          end else begin
            tmr_q     <= tmr_q + SW'(1);
            tok_run_q <= is_token_s ? tok_run_q + TW'(1) : '0;
          end
        end
        ST_LOCKED: begin
          if (is_token_s) begin
            loss_tmr_q <= '0;
          end else if (loss_tmr_q == LOSS_LAST) begin
            // Keep off_q so the previous alignment is retried first.
            state_q    <= ST_SEARCH;
            locked_q   <= 1'b0;
            loss_tmr_q <= '0;
            tmr_q      <= '0;
            tok_run_q  <= '0;
          end else begin
            loss_tmr_q <= loss_tmr_q + LW'(1);
          end
        end
        default: begin
          state_q    <= ST_SEARCH;
          locked_q   <= 1'b0;
          tok_run_q  <= '0;
          tmr_q      <= '0;
          loss_tmr_q <= '0;
        end
      endcase
    end
  end

  assign w_o          = w_s;
  assign is_token_o   = is_token_s;
  assign tok_code_o   = tok_code_s;
  assign locked_o     = locked_q;
  assign bit_offset_o = off_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS decoder for one DVI channel.
// Aligns the deserialized stream on control tokens, then decodes data symbols
// to pixel bytes and control tokens to c0/c1. Outputs are registered.
// Optional feature: define TMDS_ERR_CNT_EN to count lock-loss events in err_cnt
// (16-bit, saturating); otherwise err_cnt is tied to zero.
// Ports:
//   pclk        pixel clock
//   reset_n     asynchronous active-low reset
//   raw_din     deserialized word, bit 0 earliest
//   dout        decoded pixel data
//   c0, c1      control bits
//   de          data enable (1 = dout valid)
//   locked      symbol alignment locked
//   bit_offset  alignment offset 0..9
//   err_cnt     lock-loss event count
module tmds_channel_decoder #(
  parameter int TOKEN_CNT      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [9:0]  raw_din,
  output logic [7:0]  dout,
  output logic        c0,
  output logic        c1,
  output logic        de,
  output logic        locked,
  output logic [3:0]  bit_offset,
  output logic [15:0] err_cnt
);
  import tmds_channel_decoder_pkg::*;

  logic [9:0] w_s;
  logic       is_token_s;
  logic [1:0] tok_code_s;
  logic       locked_s;
  logic [7:0] dout_d, dout_q;
  logic       de_d, de_q;
  logic       c0_d, c0_q;
  logic       c1_d, c1_q;

  tmds_word_aligner #(
    .TOKEN_CNT      (TOKEN_CNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_aligner (
    .pclk_i       (pclk),
    .reset_ni     (reset_n),
    .raw_din_i    (raw_din),
    .w_o          (w_s),
    .is_token_o   (is_token_s),
    .tok_code_o   (tok_code_s),
    .locked_o     (locked_s),
    .bit_offset_o (bit_offset)
  );

  // Output selection: blank while unlocked, control on tokens, decoded data otherwise.
  always_comb begin
    dout_d = 8'h00;
    de_d   = 1'b0;
    c0_d   = c0_q;
    c1_d   = c1_q;
    if (!locked_s) begin
      c0_d = 1'b0;
      c1_d = 1'b0;
    end else if (is_token_s) begin
      c1_d = tok_code_s[1];
      c0_d = tok_code_s[0];
    end else begin
      de_d   = 1'b1;
      dout_d = tmds_decode_data(w_s);
    end
  end

  // Output register stage.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 8'h00;
      de_q   <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      de_q   <= de_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
    end
  end

  assign dout   = dout_q;
  assign de     = de_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign locked = locked_s;

`ifdef TMDS_ERR_CNT_EN
  logic        locked_prev_q;
  logic [15:0] err_cnt_q;

  // Count falling edges of locked, saturating at all-ones.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      locked_prev_q <= 1'b0;
      err_cnt_q     <= 16'h0000;
    end else begin
      locked_prev_q <= locked_s;
      if (locked_prev_q && !locked_s && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;
  localparam int TOKEN_CNT      = 8;
  localparam int SEARCH_TIMEOUT = 16;
  localparam int LOSS_TIMEOUT   = 64;

  logic        pclk    = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  raw_din = 10'h000;
  logic [7:0]  dout;
  logic        c0, c1, de, locked;
  logic [3:0]  bit_offset;
  logic [15:0] err_cnt;

  always #5 pclk = ~pclk;

  tmds_channel_decoder #(
    .TOKEN_CNT      (TOKEN_CNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .raw_din    (raw_din),
    .dout       (dout),
    .c0         (c0),
    .c1         (c1),
    .de         (de),
    .locked     (locked),
    .bit_offset (bit_offset),
    .err_cnt    (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [9:0] m_rq, m_rqq;
  int         m_off, m_run, m_tmr, m_loss, m_err;
  bit         m_lock, m_de, m_c0, m_c1;
  logic [7:0] m_dout;
  int         rot;
  logic [9:0] last_sym;

  function automatic bit is_tok(input logic [9:0] w, output logic [1:0] code);
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    code = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (w == toks[i]) begin
        code = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Inverse of the encoder: strip optional inversion, then each bit is the
  // difference of adjacent chained bits (complemented when bit 8 is clear).
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    int q, d, b;
    q = w[9] ? (~int'(w[7:0]) & 255) : int'(w[7:0]);
    d = q & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((q >> i) & 1) ^ ((q >> (i - 1)) & 1);
      if (!w[8]) b = b ^ 1;
      d = d | (b << i);
    end
    return 8'(d);
  endfunction

  function automatic int exp_err();
`ifdef TMDS_ERR_CNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_rq = 10'h000; m_rqq = 10'h000;
    m_off = 0; m_run = 0; m_tmr = 0; m_loss = 0; m_err = 0;
    m_lock = 1'b0; m_de = 1'b0; m_c0 = 1'b0; m_c1 = 1'b0; m_dout = 8'h00;
    rot = 0; last_sym = 10'h000;
  endtask

  task automatic model_edge();
    logic [19:0] s;
    logic [9:0]  w;
    logic [1:0]  code;
    bit          tok;
    s   = {m_rq, m_rqq};
    s   = s >> m_off;
    w   = s[9:0];
    tok = is_tok(w, code);
    if (!m_lock) begin
      m_de = 1'b0; m_c0 = 1'b0; m_c1 = 1'b0; m_dout = 8'h00;
    end else if (tok) begin
      m_de = 1'b0; m_c1 = code[1]; m_c0 = code[0]; m_dout = 8'h00;
    end else begin
      m_de = 1'b1; m_dout = ref_decode(w);
    end
    if (!m_lock) begin
      if (tok && (m_run + 1 == TOKEN_CNT)) begin
        m_lock = 1'b1; m_run = 0; m_tmr = 0; m_loss = 0;
      end else if (m_tmr + 1 == SEARCH_TIMEOUT) begin
        m_off = (m_off + 1) % 10; m_tmr = 0; m_run = 0;
      end else begin
        m_tmr = m_tmr + 1;
        m_run = tok ? m_run + 1 : 0;
      end
    end else begin
      if (tok) m_loss = 0;
      else if (m_loss + 1 == LOSS_TIMEOUT) begin
        m_lock = 1'b0; m_loss = 0; m_tmr = 0; m_run = 0;
        if (m_err < 65535) m_err = m_err + 1;
      end else m_loss = m_loss + 1;
    end
    m_rqq = m_rq;
    m_rq  = raw_din;
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
  endtask

  // Serialize a symbol so that it lands at window offset 'rot'.
  task automatic send_sym(input logic [9:0] sym);
    logic [19:0] t;
    t = ({10'h000, sym} << rot) | ({10'h000, last_sym} >> (10 - rot));
    raw_din  = t[9:0];
    last_sym = sym;
    step();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    reset_n = 1'b1;
    model_reset();
    raw_din = 10'h000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      raw_din = 10'($urandom_range(0, 1023));
      @(posedge pclk);
      #1;
      total++;
      if ({dout, c0, c1, de, locked, bit_offset, err_cnt} !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold: got dout=%h c0=%b c1=%b de=%b locked=%b off=%0d err=%0d, want all 0",
                 dout, c0, c1, de, locked, bit_offset, err_cnt);
      end
    end
    reset_n = 1'b1;
    raw_din = 10'h000;
    #1;
    total++;
    if (locked !== 1'b0 || bit_offset !== 4'd0) begin
      bad++;
      $display("FAIL reset_release: got locked=%b off=%0d, want 0/0", locked, bit_offset);
    end
  endtask

  task automatic test_aligned_lock();
    for (int i = 0; i < 20; i++) begin
      send_sym(10'h354);
      total++;
      if ({locked, bit_offset, de, c1, c0, dout} !== {m_lock, 4'(m_off), m_de, m_c1, m_c0, m_dout}) begin
        bad++;
        $display("FAIL aligned_cycle %0d: got lk=%b off=%0d de=%b c=%b%b d=%h, want lk=%b off=%0d de=%b c=%b%b d=%h",
                 i, locked, bit_offset, de, c1, c0, dout, m_lock, m_off, m_de, m_c1, m_c0, m_dout);
      end
    end
    total++;
    if (locked !== 1'b1 || bit_offset !== 4'd0 || de !== 1'b0 || {c1, c0} !== 2'b00) begin
      bad++;
      $display("FAIL aligned_lock: got lk=%b off=%0d de=%b c=%b%b, want 1/0/0/00", locked, bit_offset, de, c1, c0);
    end
    repeat (3) send_sym(10'h2AB);
    total++;
    if ({c1, c0} !== 2'b11 || de !== 1'b0) begin
      bad++;
      $display("FAIL token_11: got c=%b%b de=%b, want 11/0", c1, c0, de);
    end
  endtask

  task automatic test_rotated_search();
    int offs[$];
    apply_reset();
    rot = 3;
    for (int i = 0; i < 80; i++) begin
      send_sym(10'h0AB);
      if (offs.size() == 0 || offs[offs.size() - 1] != int'(bit_offset)) offs.push_back(int'(bit_offset));
      total++;
      if ({locked, bit_offset, de, c1, c0, dout} !== {m_lock, 4'(m_off), m_de, m_c1, m_c0, m_dout}) begin
        bad++;
        $display("FAIL search_cycle %0d: got lk=%b off=%0d de=%b c=%b%b, want lk=%b off=%0d de=%b c=%b%b",
                 i, locked, bit_offset, de, c1, c0, m_lock, m_off, m_de, m_c1, m_c0);
      end
    end
    total++;
    if (offs.size() != 4 || offs[0] != 0 || offs[1] != 1 || offs[2] != 2 || offs[3] != 3) begin
      bad++;
      $display("FAIL offset_steps: got %0d distinct offsets %p, want 0,1,2,3", offs.size(), offs);
    end
    total++;
    if (locked !== 1'b1 || bit_offset !== 4'd3 || {c1, c0} !== 2'b01) begin
      bad++;
      $display("FAIL rotated_lock: got lk=%b off=%0d c=%b%b, want 1/3/01", locked, bit_offset, c1, c0);
    end
  endtask

  task automatic test_data_decode();
    logic [9:0] syms [6];
    logic [7:0] seen[$];
    logic [1:0] code;
    logic [9:0] s;
    syms = '{10'h100, 10'h200, 10'h0AB, 10'h0AB, 10'h0AB, 10'h0AB};
    for (int i = 0; i < 6; i++) begin
      send_sym(syms[i]);
      if (de === 1'b1) seen.push_back(dout);
      total++;
      if ({de, c1, c0, dout} !== {m_de, m_c1, m_c0, m_dout} || {c1, c0} !== 2'b01) begin
        bad++;
        $display("FAIL fixed_data %0d: got de=%b c=%b%b d=%h, want de=%b c=%b%b d=%h (c=01)",
                 i, de, c1, c0, dout, m_de, m_c1, m_c0, m_dout);
      end
    end
    total++;
    if (seen.size() != 2 || seen[0] !== 8'h00 || seen[1] !== 8'hFF) begin
      bad++;
      $display("FAIL fixed_data_seq: got %p, want 00,FF", seen);
    end
    for (int i = 0; i < 192; i++) begin
      if (i % 16 == 15) s = (i % 32 == 15) ? 10'h154 : 10'h2AB;
      else s = 10'($urandom_range(0, 1023));
      send_sym(s);
      total++;
      if ({locked, de, c1, c0, dout} !== {m_lock, m_de, m_c1, m_c0, m_dout}) begin
        bad++;
        $display("FAIL random_data %0d: sym=%h got lk=%b de=%b c=%b%b d=%h, want lk=%b de=%b c=%b%b d=%h",
                 i, s, locked, de, c1, c0, dout, m_lock, m_de, m_c1, m_c0, m_dout);
      end
    end
    code = 2'b00;
    repeat (3) send_sym(10'h0AB);
    if (is_tok(10'h0AB, code)) begin
      total++;
      if ({c1, c0} !== code || locked !== 1'b1) begin
        bad++;
        $display("FAIL post_random: got c=%b%b lk=%b, want %b/1", c1, c0, locked, code);
      end
    end
  endtask

  task automatic test_loss_relock();
    int n;
    n = 0;
    while (m_lock && n < LOSS_TIMEOUT + 10) begin
      send_sym(10'h100);
      n++;
      total++;
      if ({locked, bit_offset, de, dout} !== {m_lock, 4'(m_off), m_de, m_dout}) begin
        bad++;
        $display("FAIL loss_cycle %0d: got lk=%b off=%0d de=%b d=%h, want lk=%b off=%0d de=%b d=%h",
                 n, locked, bit_offset, de, dout, m_lock, m_off, m_de, m_dout);
      end
    end
    repeat (2) send_sym(10'h100);
    total++;
    if (locked !== 1'b0 || de !== 1'b0 || bit_offset !== 4'd3 || int'(err_cnt) != exp_err()) begin
      bad++;
      $display("FAIL lock_loss: got lk=%b de=%b off=%0d err=%0d, want 0/0/3/%0d",
               locked, de, bit_offset, err_cnt, exp_err());
    end
    for (int i = 0; i < 14; i++) begin
      send_sym(10'h354);
      total++;
      if ({locked, bit_offset, de, c1, c0} !== {m_lock, 4'(m_off), m_de, m_c1, m_c0}) begin
        bad++;
        $display("FAIL relock_cycle %0d: got lk=%b off=%0d de=%b c=%b%b, want lk=%b off=%0d de=%b c=%b%b",
                 i, locked, bit_offset, de, c1, c0, m_lock, m_off, m_de, m_c1, m_c0);
      end
    end
    total++;
    if (locked !== 1'b1 || bit_offset !== 4'd3 || {c1, c0} !== 2'b00) begin
      bad++;
      $display("FAIL relock: got lk=%b off=%0d c=%b%b, want 1/3/00", locked, bit_offset, c1, c0);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) send_sym(10'h200);
    total++;
    if (locked !== 1'b1 || de !== 1'b1 || dout !== m_dout) begin
      bad++;
      $display("FAIL pre_reset: got lk=%b de=%b d=%h, want 1/1/%h", locked, de, dout, m_dout);
    end
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (locked !== 1'b0 || de !== 1'b0 || dout !== 8'h00 || bit_offset !== 4'd0 || err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: got lk=%b de=%b d=%h off=%0d err=%0d, want all 0",
               locked, de, dout, bit_offset, err_cnt);
    end
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    model_reset();
    raw_din = 10'h000;
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_rotated_search();
    test_data_decode();
    test_loss_relock();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
